// File: rtl/fp_mul_pkg.sv
// Shared widths, iteration counts and FSM state type for the FP significand multiplier.
// Optional build macro MANT_MUL_RADIX4_EN selects the radix-4 iteration (2 multiplier bits per cycle).
package fp_mul_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

`ifdef MANT_MUL_RADIX4_EN
    localparam int RADIX_BITS = 2;
`else
    localparam int RADIX_BITS = 1;
`endif

    function automatic int mant_w(input int is_double);
        return (is_double != 0) ? 53 : 24;
    endfunction

    function automatic int prod_w(input int is_double);
        return 2 * mant_w(is_double);
    endfunction

    // The multiplier operand is zero-extended to a whole number of digits.
    function automatic int iter_cnt(input int is_double);
        return (mant_w(is_double) + RADIX_BITS - 1) / RADIX_BITS;
    endfunction

    function automatic int cnt_w(input int is_double);
        return $clog2(iter_cnt(is_double));
    endfunction

endpackage

// File: rtl/mant_mul_step.sv
// One shift-add iteration of the significand multiplier (combinational).
// Build macro MANT_MUL_RADIX4_EN selects radix-4 (adds 0/A/2A/3A, shifts by 2) instead of radix-2.
module mant_mul_step #(
    parameter int W  = 24,
    parameter int LW = 24
) (
    input  logic [W+LW-1:0] p,
    input  logic [W-1:0]    a_reg,
`ifdef MANT_MUL_RADIX4_EN
    input  logic [W+1:0]    a3_reg,
`endif
    output logic [W+LW-1:0] p_nxt
);

`ifdef MANT_MUL_RADIX4_EN
    logic [W+1:0] addend;
    logic [W+1:0] sum;

    always_comb begin
        addend = '0;
        unique case (p[1:0])
            2'd0: addend = '0;
            2'd1: addend = {2'b00, a_reg};
            2'd2: addend = {1'b0, a_reg, 1'b0};
            2'd3: addend = a3_reg;
        endcase
        // High half stays below 2^W, so hi + 3A always fits in W+2 bits.
        sum   = {2'b00, p[W+LW-1:LW]} + addend;
        p_nxt = {sum, p[LW-1:2]};
    end
`else
    logic [W:0] sum;

    always_comb begin
        sum   = {1'b0, p[W+LW-1:LW]} + (p[0] ? {1'b0, a_reg} : '0);
        p_nxt = {sum, p[LW-1:1]};
    end
`endif

endmodule

// File: rtl/mant_seq_multiplier.sv
// Sequential shift-add significand multiplier producing the exact 2W-bit product for the rounder.
// Build macro MANT_MUL_RADIX4_EN switches to radix-4 iteration; handshake and output format are unchanged.
module mant_seq_multiplier
    import fp_mul_pkg::*;
#(
    parameter  int IS_DOUBLE = 0,
    localparam int W         = mant_w(IS_DOUBLE),
    localparam int PROD_W    = prod_w(IS_DOUBLE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              norm_hi,
    output logic              busy
);

    localparam int ITER = iter_cnt(IS_DOUBLE);
    localparam int CW   = cnt_w(IS_DOUBLE);
    localparam int LW   = ITER * RADIX_BITS;
    localparam int PW   = W + LW;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_reg;
`ifdef MANT_MUL_RADIX4_EN
    logic [W+1:0]  a3_reg;
`endif
    logic [PW-1:0] p;
    logic [PW-1:0] p_nxt;
    logic [CW-1:0] cnt;
    logic          last_iter;

    assign last_iter = (cnt == CW'(ITER - 1));
    assign norm_hi   = product[PROD_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake: a transfer happens on a clock edge where valid and ready are both high.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == BUSY);
        out_valid = (state == DONE);
    end

    mant_mul_step #(
        .W (W),
        .LW(LW)
    ) u_step (
        .p     (p),
        .a_reg (a_reg),
`ifdef MANT_MUL_RADIX4_EN
        .a3_reg(a3_reg),
`endif
        .p_nxt (p_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
`ifdef MANT_MUL_RADIX4_EN
            a3_reg  <= '0;
`endif
            p       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_reg  <= a;
`ifdef MANT_MUL_RADIX4_EN
                a3_reg <= {2'b00, a} + {1'b0, a, 1'b0};
`endif
                p      <= {{W{1'b0}}, LW'(b)};
                cnt    <= '0;
            end
            if (state == BUSY) begin
                p   <= p_nxt;
                cnt <= cnt + CW'(1);
                if (last_iter) begin
                    product <= p_nxt[PROD_W-1:0];
                end
            end
        end
    end

    // With an odd W under radix-4 the padded accumulator has a top bit that is always zero.
    if (PW > PROD_W) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^p_nxt[PW-1:PROD_W];
    end

endmodule

// File: doc/mant_seq_multiplier.md
Name: mant_seq_multiplier

Overview:
Sequential shift-add multiplier for the FP multiplier datapath. Takes two unsigned significands (hidden bit included) and produces the full double-width product. That product is the exact format the downstream rounding stage consumes: high half is the kept mantissa, low half carries the guard/sticky bits. The block sits between exponent/sign unpack and rounding. It uses a valid/ready handshake on both sides so the rounder can stall it.

Parameters:
IS_DOUBLE, 0, 0: single precision, W=24, product 48 bits; 1: double precision, W=53, product 106 bits

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operands a/b valid
in_ready  out  1  block can accept operands (high only in IDLE)
a  in  W  multiplicand significand, unsigned
b  in  W  multiplier significand, unsigned
out_valid  out  1  product valid, held until accepted
out_ready  in  1  downstream (rounder) accepts product
product  out  2W  a*b, exact, unsigned
norm_hi  out  1  equals product[2W-1]; tells the rounder/exponent logic a 1-bit normalisation shift is needed
busy  out  1  high in BUSY state

Behaviour:
- Clocking and reset: all state updates on posedge clk; rst synchronous, active-high.
- Reset values: state=IDLE, out_valid=0, product=0, norm_hi=0, busy=0, counter=0. in_ready=1 from the first cycle after the reset edge.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a into A_reg. Load P={ (W+1)'0, b }. Clear the counter. Go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle: sum[W:0] = P_hi + (P_lo[0] ? A_reg : 0), then P <= {sum, P_lo} >> 1. The counter increments each cycle. After W iterations (counter==W-1 on that edge), go to DONE. Load product <= P result and set out_valid=1 on the same edge.
  - DONE: out_valid=1; product and norm_hi stable. On out_valid&out_ready, clear out_valid and go to IDLE. in_ready=1 on the following cycle.
- Latency: out_valid rises exactly W clocks after the accept edge (24 or 53).
- Throughput: one operation per W+2 cycles when out_ready is held high.
- No new operand is accepted in BUSY or DONE. in_valid during those states is ignored; the producer must hold it.
- Arithmetic:
  - The accumulator is W+1 bits wide, so the carry is never lost.
  - The final product is exact; no truncation or rounding happens in this block.
  - norm_hi is combinational from the product register.
  - Operand zero is not special-cased; it runs the full W cycles and gives product=0.
- Backpressure: while out_ready=0 in DONE, product is frozen indefinitely.
- Reset mid-operation: rst in BUSY or DONE aborts the operation. Next cycle: IDLE, out_valid=0, product=0; the partial result is discarded.
- Simultaneous events: in_valid is ignored when out_valid&out_ready fire in the same cycle. The next accept happens in IDLE at the earliest.

Optional Feature:
MANT_MUL_RADIX4_EN:
- Defined: radix-4 iteration, 2 multiplier bits per cycle.
  - 3*A_reg is precomputed on accept (one extra adder, registered with A_reg).
  - Each cycle adds {0, A, 2A, 3A} selected by P_lo[1:0], then shifts right by 2.
  - b is zero-extended to an even width (54 bits when IS_DOUBLE=1).
  - Latency ceil(W/2): 12 (single) / 27 (double).
- Undefined: radix-2 as described above.
- Handshake, reset and output format are identical in both builds.

Decomposition:
- Package fp_mul_pkg:
  - width functions/constants: MANT_W(IS_DOUBLE), PROD_W=2*MANT_W, ITER_CNT (radix-dependent);
  - state enum {IDLE, BUSY, DONE};
  - counter width as a constant ($clog2(ITER_CNT)).
- One sub-module: mant_mul_step, a combinational single-iteration adder+shift (radix-2 or radix-4 selected by the macro). The top level keeps the FSM, counter and registers.

Test Plan:
- Single, radix-2:
  - a=b=0x800000, accept then hold out_ready=1 -> out_valid exactly 24 cycles after accept, product=0x400000000000, norm_hi=0.
  - a=b=0xFFFFFF -> product=0xFFFFFE000001, norm_hi=1.
- Backpressure: a=0xC00000, b=0xA00000, out_ready=0 for 5 cycles after out_valid -> product=0x780000000000 held, in_ready=0 throughout. out_ready=1 -> out_valid drops next cycle, then in_ready=1.
- Reset mid-op: rst pulsed at cycle 10 of BUSY -> next cycle out_valid=0, product=0, in_ready=1. A new op a=b=0x800000 completes correctly with no residue.
- Double, IS_DOUBLE=1: a=b=2^52 -> product bit 104 only set, norm_hi=0, latency 53. a=b=2^53-1 -> product=2^106-2^54+1, norm_hi=1.
- MANT_MUL_RADIX4_EN defined: repeat the first scenario -> latency 12 (single) and 27 (double). 1000 random operand pairs must match the radix-2 results bit-for-bit.
